controlador_7seg_multiplexado: RTL
==================================

# controlador_7seg_multiplexado

Parametrised, time-multiplexed seven-segment display controller for the Basys3 board. It accepts a W-bit value, either plain binary or Gray code, and converts it to D BCD digits with a sequential double-dabble engine. It then scans the digits onto the shared active-low segment and anode lines. The block generalises the team's two-digit display path with a configurable digit count, an optional Gray-input mode, leading-zero blanking and overflow indication.

## Interface
Parameters:
- `W`, 8, input value width; legal range 1..16.
- `D`, 4, number of digits; legal range 1..8.
- `REFRESH_DIV`, 100000, clock cycles each digit stays enabled; must be ≥ 2.

Ports:
- `clk`  in  1  the single clock; all logic is on its rising edge.
- `rst_n`  in  1  synchronous, active-low reset, sampled on the rising edge of `clk`.
- `valor`  in  W  value to display; sampled only on an accepted load.
- `gray_en`  in  1  sampled with `cargar`.
  - 1: `valor` is Gray code and is converted to binary before BCD conversion.
  - 0: `valor` is plain binary.
- `cargar`  in  1  load strobe. Accepted only when `ocupado`=0.
- `blank_ceros`  in  1  1 = blank leading zeros. Digit 0 is never blanked.
- `ocupado`  out  1  conversion in progress.
- `overflow`  out  1  captured value > 10^D−1; updated at commit.
- `seg`  out  7  active-low segments, bit6 = a … bit0 = g. Registered.
- `an`  out  D  active-low digit enables, one-hot-low. Registered.

## Operation
- Gray→binary conversion happens at capture: bin[W−1] = g[W−1]; bin[i] = bin[i+1] ^ g[i].
- FSM states and transitions:
  - IDLE → CONV on `cargar`=1. This captures the (converted) value and the overflow compare (value > 10^D−1).
  - CONV runs exactly W shift iterations.
    - Each cycle, any BCD nibble ≥ 5 first gets +3, then the register {bcd[4D−1:0], bin} shifts left by 1.
    - The BCD register is 4D bits; bits shifted out of the top are discarded.
  - CONV → COMMIT after the W-th iteration.
  - COMMIT: copies BCD to the display register, latches `overflow`, returns to IDLE.
- `cargar` while `ocupado`=1 is ignored, with no queueing.
- Display register holds the last committed value until the next commit.
- Digit glyphs (active-low, abcdefg):
  - 0 = 0000001, 1 = 1001111, 2 = 0010010, 3 = 0000110, 4 = 1001100
  - 5 = 0100100, 6 = 0100000, 7 = 0001111, 8 = 0000000, 9 = 0000100
  - blank = 1111111, dash = 1111110
- Per-digit output priority, highest first:
  1. `overflow`=1 → dash on every digit.
  2. `blank_ceros`=1, i ≠ 0, and digits i..D−1 all zero → blank.
  3. Otherwise → glyph of digit i.
- Scan:
  - Refresh counter runs 0..REFRESH_DIV−1. At wrap, digit index advances i → (i+1) mod D.
  - Digit 0 is the units digit, driven by `an`[0].
  - With D=1, `an` is constantly 0 after reset.

## Timing
- Reset values (while `rst_n`=0 at an edge):
  - `ocupado`=0, `overflow`=0
  - `an`=all 1, `seg`=1111111
  - display register=0, digit index=0, refresh counter=0, FSM=IDLE
- First edge after reset release: `an`=…1110, `seg`=0 glyph.
- `cargar` sampled high at edge k (IDLE):
  - `ocupado`=1 from k+1 through k+W+1, i.e. W+1 cycles, then 0.
  - The new value appears on `seg` from edge k+W+2 for the currently scanned digit.
- `seg`/`an` are registered from the digit index and display register of the previous cycle. A commit mid-scan changes `seg` without disturbing the scan phase.
- Reset mid-conversion aborts it. The display returns to 0; no partial value is ever committed.
- Simultaneous `cargar` and commit cycle: `cargar` is ignored, since `ocupado` is still 1.
- `gray_en` and `blank_ceros` changes:
  - `gray_en` affects only subsequent loads.
  - `blank_ceros` takes effect on the next registered `seg` update.

## Test plan
Bench parameters: W=8, D=4, REFRESH_DIV=4 unless noted.
- **Reset and scan:** `rst_n`=0 → `an`=1111, `seg`=1111111. After release → `an` steps 1110, 1101, 1011, 0111, 1110, one step every 4 cycles, with `seg`=0000001 on every digit.
- **Binary load:** `valor`=173, `gray_en`=0, `blank_ceros`=1 → `ocupado` high for exactly 9 cycles. Then:
  - digit0 = 0000110, digit1 = 0001111, digit2 = 1001111
  - digit3 = 1111111 (blanked)
- **Gray load:** `valor`=8'b11001110, `gray_en`=1 → binary 139. With `blank_ceros`=0, digits 3..0 = 0000001, 1001111, 0000110, 0000100.
- **Overflow:** with W=16, D=4:
  - `valor`=10000 → `overflow`=1, all digits 1111110.
  - Then `valor`=9999 → `overflow`=0, all digits 0000100.
- **Load while busy:** load 42, then assert `cargar` with `valor`=99 two cycles later → display shows 42, and `ocupado` stays high for only 9 cycles in total.
- **Reset mid-conversion:** load 200, then `rst_n`=0 at the 4th `ocupado` cycle → after release, `ocupado`=0, `overflow`=0, and all digits show 0000001.

Source files
------------

// File: rtl/controlador_7seg_multiplexado.sv
// Time-multiplexed seven-segment controller: the value is captured (optionally Gray-decoded),
// converted to BCD by a sequential double-dabble, and the committed digits are scanned onto active-low lines.
module controlador_7seg_multiplexado #(
    parameter int W           = 8,
    parameter int D           = 4,
    parameter int REFRESH_DIV = 100000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] valor,
    input  logic         gray_en,
    input  logic         cargar,
    input  logic         blank_ceros,
    output logic         ocupado,
    output logic         overflow,
    output logic [6:0]   seg,
    output logic [D-1:0] an
);

    localparam int BW = 4 * D;
    localparam int NW = $clog2(W + 1);
    localparam int CW = $clog2(REFRESH_DIV);
    localparam int IW = (D > 1) ? $clog2(D) : 1;
    localparam logic [CW-1:0] CNT_MAX  = CW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX  = IW'(D - 1);
    localparam logic [NW-1:0] ITER_MAX = NW'(W - 1);

    function automatic logic [31:0] calc_max_val();
        logic [31:0] m;
        m = 32'd1;
        for (int d = 0; d < D; d++) begin
            m = m * 32'd10;
        end
        return m - 32'd1;
    endfunction

    localparam logic [31:0] MAX_VAL = calc_max_val();

    function automatic logic [W-1:0] gray2bin(input logic [W-1:0] g);
        logic [W-1:0] b;
        b[W-1] = g[W-1];
        for (int i = W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [BW-1:0] add3(input logic [BW-1:0] v);
        logic [BW-1:0] r;
        r = v;
        for (int n = 0; n < D; n++) begin
            if (r[4*n +: 4] >= 4'd5) begin
                r[4*n +: 4] = r[4*n +: 4] + 4'd3;
            end else begin
                r[4*n +: 4] = r[4*n +: 4];
            end
        end
        return r;
    endfunction

    function automatic logic [6:0] glyph(input logic [3:0] dig);
        case (dig)
            4'd0:    return 7'b0000001;
            4'd1:    return 7'b1001111;
            4'd2:    return 7'b0010010;
            4'd3:    return 7'b0000110;
            4'd4:    return 7'b1001100;
            4'd5:    return 7'b0100100;
            4'd6:    return 7'b0100000;
            4'd7:    return 7'b0001111;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0000100;
            default: return 7'b1111111;
        endcase
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CONV   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    state_t        state_r, state_s;
    logic [W-1:0]  bin_r;
    logic [W-1:0]  cap_s;
    logic [BW-1:0] bcd_r;
    logic [BW-1:0] adj_s;
    logic [NW-1:0] iter_r;
    logic          ovf_pend_r;
    logic [BW-1:0] disp_r;
    logic [CW-1:0] cnt_r;
    logic [IW-1:0] idx_r;
    logic [3:0]    digit_s;
    logic          hi_zero_s;
    logic [6:0]    seg_s;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; the W-th shift (iter_r == W-1) hands over to commit
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (cargar) begin
                    state_s = ST_CONV;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CONV: begin
                if (iter_r == ITER_MAX) begin
                    state_s = ST_COMMIT;
                end else begin
                    state_s = ST_CONV;
                end
            end
            ST_COMMIT: state_s = ST_IDLE;
            default:   state_s = ST_IDLE;
        endcase
    end

    // Capture value and pre-adjusted BCD for the current shift
    always_comb begin
        cap_s = valor;
        if (gray_en) begin
            cap_s = gray2bin(valor);
        end else begin
            cap_s = valor;
        end
        adj_s = add3(bcd_r);
    end

    // Conversion datapath, commit and busy flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bin_r      <= '0;
            bcd_r      <= '0;
            iter_r     <= '0;
            ovf_pend_r <= 1'b0;
            disp_r     <= '0;
            overflow   <= 1'b0;
            ocupado    <= 1'b0;
        end else begin
            ocupado <= (state_s != ST_IDLE);
            case (state_r)
                ST_IDLE: begin
                    if (cargar) begin
                        bin_r      <= cap_s;
                        bcd_r      <= '0;
                        iter_r     <= '0;
                        ovf_pend_r <= (32'(cap_s) > MAX_VAL);
                    end
                end
                ST_CONV: begin
                    bcd_r  <= {adj_s[BW-2:0], bin_r[W-1]};
                    bin_r  <= bin_r << 1;
                    iter_r <= iter_r + NW'(1);
                end
                ST_COMMIT: begin
                    disp_r   <= bcd_r;
                    overflow <= ovf_pend_r;
                end
                default: begin
                    bin_r <= bin_r;
                end
            endcase
        end
    end

    // Refresh counter and scanned digit index
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r <= '0;
            idx_r <= '0;
        end else if (cnt_r == CNT_MAX) begin
            cnt_r <= '0;
            idx_r <= (idx_r == IDX_MAX) ? '0 : idx_r + IW'(1);
        end else begin
            cnt_r <= cnt_r + CW'(1);
        end
    end

    // Segment selection: dash on overflow beats leading-zero blanking
    always_comb begin
        digit_s   = disp_r[4*idx_r +: 4];
        hi_zero_s = ((disp_r >> (4 * idx_r)) == '0);
        seg_s     = 7'b1111111;
        if (overflow) begin
            seg_s = 7'b1111110;
        end else if (blank_ceros && (idx_r != '0) && hi_zero_s) begin
            seg_s = 7'b1111111;
        end else begin
            seg_s = glyph(digit_s);
        end
    end

    // Registered display outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg <= 7'b1111111;
            an  <= '1;
        end else begin
            seg <= seg_s;
            an  <= ~(D'(1) << idx_r);
        end
    end

endmodule
